// File: rtl/serial_word_rcvr.sv
// Serial word receiver: oversamples a rcv_clk/fs/data link in sys_clk, assembles MSB-first
// words into a first-word-fall-through FIFO. Define RCVR_TIMEOUT_EN to add a stalled-word timeout.
module serial_word_rcvr #(
  parameter int WORD_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
`ifdef RCVR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        rcv_clk,
  input  logic                        i_rcv_fs,
  input  logic                        i_rcv_data,
  input  logic                        i_flush,
  input  logic                        i_clr_err,
  output logic [WORD_W-1:0]           o_st_data,
  output logic                        o_st_vld,
  input  logic                        i_st_rdy,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_ovf,
  output logic                        o_frm_err,
  output logic [7:0]                  o_err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WORD_W + 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_p0;
  logic [SYNC_STAGES-1:0] fs_sync_p0;
  logic [SYNC_STAGES-1:0] dat_sync_p0;
  logic                   clk_hist_p1;
  logic                   smp_vld_p1;
  logic                   smp_fs_p1;
  logic                   smp_dat_p1;

  state_t              state, state_nxt;
  logic [CW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [WORD_W-1:0]   shreg, shreg_nxt;
  logic                push_req;
  logic                frm_evt;

  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  logic                full, empty, do_push, do_pop, ovf_evt;

`ifdef RCVR_TIMEOUT_EN
  logic [15:0]         idle_cnt;
  logic                to_evt;
`endif

  // Stage p0: synchronizers; p1: rcv_clk edge history and sample event
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_p0 <= '0;
      fs_sync_p0  <= '0;
      dat_sync_p0 <= '0;
      clk_hist_p1 <= 1'b0;
    end else begin
      clk_sync_p0 <= {clk_sync_p0[SYNC_STAGES-2:0], rcv_clk};
      fs_sync_p0  <= {fs_sync_p0[SYNC_STAGES-2:0], i_rcv_fs};
      dat_sync_p0 <= {dat_sync_p0[SYNC_STAGES-2:0], i_rcv_data};
      clk_hist_p1 <= clk_sync_p0[SYNC_STAGES-1];
    end
  end

  assign smp_vld_p1 = clk_sync_p0[SYNC_STAGES-1] & ~clk_hist_p1;
  assign smp_fs_p1  = fs_sync_p0[SYNC_STAGES-1];
  assign smp_dat_p1 = dat_sync_p0[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Deserializer: push occurs on the sample that completes the word
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    push_req    = 1'b0;
    frm_evt     = 1'b0;
    if (smp_vld_p1) begin
      case (state)
        ST_IDLE: begin
          if (smp_fs_p1) begin
            state_nxt    = ST_SHIFT;
            bit_cnt_nxt  = CW'(1);
            shreg_nxt    = '0;
            shreg_nxt[0] = smp_dat_p1;
          end
        end
        ST_SHIFT: begin
          if (smp_fs_p1) begin
            frm_evt      = 1'b1;
            bit_cnt_nxt  = CW'(1);
            shreg_nxt    = '0;
            shreg_nxt[0] = smp_dat_p1;
          end else begin
            shreg_nxt = {shreg[WORD_W-2:0], smp_dat_p1};
            if (bit_cnt == CW'(WORD_W - 1)) begin
              push_req    = 1'b1;
              state_nxt   = ST_IDLE;
              bit_cnt_nxt = '0;
            end else begin
              bit_cnt_nxt = bit_cnt + CW'(1);
            end
          end
        end
        default: begin
          state_nxt   = ST_IDLE;
          bit_cnt_nxt = '0;
          shreg_nxt   = '0;
        end
      endcase
    end
`ifdef RCVR_TIMEOUT_EN
    else if (to_evt) begin
      frm_evt     = 1'b1;
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      shreg_nxt   = '0;
    end
`endif
    if (i_flush) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      shreg_nxt   = '0;
      push_req    = 1'b0;
      frm_evt     = 1'b0;
    end
  end

`ifdef RCVR_TIMEOUT_EN
  assign to_evt = (state == ST_SHIFT) && !smp_vld_p1 && (idle_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (i_flush || state != ST_SHIFT || smp_vld_p1 || to_evt) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`endif

  // FIFO: a pop in the same cycle frees the slot for a push even when full
  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = !empty && i_st_rdy && !i_flush;
  assign do_push = push_req && (!full || do_pop);
  assign ovf_evt = push_req && full && !do_pop;

  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= shreg_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign o_st_vld  = !empty;
  assign o_st_data = empty ? '0 : mem[rd_ptr];
  assign o_level   = level;

  // Sticky errors: a same-cycle error event takes precedence over the clear
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ovf     <= 1'b0;
      o_frm_err <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      if (ovf_evt)        o_ovf <= 1'b1;
      else if (i_clr_err) o_ovf <= 1'b0;
      if (frm_evt) begin
        o_frm_err <= 1'b1;
        o_err_cnt <= i_clr_err ? 8'd1 : sat_inc(o_err_cnt);
      end else if (i_clr_err) begin
        o_frm_err <= 1'b0;
        o_err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rcvr.sv
// Directed bench for serial_word_rcvr: drives the serial link from sys_clk negedges and
// collects stream beats into a queue compared against hand-computed words.
`timescale 1ns/1ps
module tb_serial_word_rcvr;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        rcv_clk = 1'b0;
  logic        rcv_fs  = 1'b0;
  logic        rcv_data = 1'b0;
  logic        flush   = 1'b0;
  logic        clr_err = 1'b0;
  logic        st_rdy  = 1'b0;
  logic [15:0] st_data;
  logic        st_vld;
  logic [3:0]  level;
  logic        ovf;
  logic        frm_err;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] rx_q[$];

  always #5 sys_clk = ~sys_clk;

  serial_word_rcvr dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .rcv_clk    (rcv_clk),
    .i_rcv_fs   (rcv_fs),
    .i_rcv_data (rcv_data),
    .i_flush    (flush),
    .i_clr_err  (clr_err),
    .o_st_data  (st_data),
    .o_st_vld   (st_vld),
    .i_st_rdy   (st_rdy),
    .o_level    (level),
    .o_ovf      (ovf),
    .o_frm_err  (frm_err),
    .o_err_cnt  (err_cnt)
  );

  // Beats are recorded 1 ns before the posedge that transfers them
  always @(negedge sys_clk) begin
    #4;
    if (rst_n && st_vld && st_rdy) rx_q.push_back(st_data);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rxw(input int i);
    return (i < rx_q.size()) ? {16'h0, rx_q[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic fs, input logic d);
    rcv_clk  = 1'b0;
    rcv_fs   = fs;
    rcv_data = d;
    @(negedge sys_clk);
    rcv_clk = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(i == 15, w[i]);
  endtask

  task automatic link_idle();
    rcv_clk  = 1'b0;
    rcv_fs   = 1'b0;
    rcv_data = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge sys_clk);
    clr_err = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    wait_cyc(3);
    chk("rst_vld",     {31'h0, st_vld},  32'h0);
    chk("rst_data",    {16'h0, st_data}, 32'h0);
    chk("rst_level",   {28'h0, level},   32'h0);
    chk("rst_ovf",     {31'h0, ovf},     32'h0);
    chk("rst_frm_err", {31'h0, frm_err}, 32'h0);
    chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Three back-to-back words with the stream always ready
    st_rdy = 1'b1;
    for (int w = 0; w < 3; w++) send_word(16'(w));
    link_idle();
    wait_cyc(6);
    chk("t1_count", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_word", rxw(i), i);
    chk("t1_frm_err", {31'h0, frm_err}, 32'h0);
    chk("t1_ovf",     {31'h0, ovf},     32'h0);

    // Stalled consumer: word must be held for 1 us, then one beat
    st_rdy = 1'b0;
    rx_q.delete();
    send_word(16'hA5C3);
    link_idle();
    wait_cyc(4);
    bad = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (!st_vld || st_data !== 16'hA5C3) bad++;
    end
    chk("t2_hold_bad", bad, 0);
    chk("t2_level", {28'h0, level}, 32'h1);
    st_rdy = 1'b1;
    wait_cyc(4);
    chk("t2_count", rx_q.size(), 1);
    chk("t2_word", rxw(0), 32'hA5C3);
    chk("t2_level_after", {28'h0, level}, 32'h0);

    // Overflow: 12 words into 8 slots
    st_rdy = 1'b0;
    rx_q.delete();
    for (int k = 0; k < 12; k++) send_word(16'h0100 + 16'(k));
    link_idle();
    wait_cyc(6);
    chk("t3_level_full", {28'h0, level},   32'h8);
    chk("t3_ovf",        {31'h0, ovf},     32'h1);
    chk("t3_head",       {16'h0, st_data}, 32'h0100);
    st_rdy = 1'b1;
    wait_cyc(12);
    chk("t3_count", rx_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("t3_word", rxw(i), 32'h0100 + i);
    chk("t3_level_empty", {28'h0, level}, 32'h0);
    pulse_clr();
    chk("t3_ovf_clr", {31'h0, ovf}, 32'h0);

    // Framing error: fs returns after 7 bits, then a full word
    rx_q.delete();
    for (int i = 0; i < 7; i++) send_bit(i == 0, 1'b1);
    send_word(16'h1234);
    link_idle();
    wait_cyc(6);
    chk("t4_frm_err", {31'h0, frm_err}, 32'h1);
    chk("t4_err_cnt", {24'h0, err_cnt}, 32'h1);
    chk("t4_count",   rx_q.size(), 1);
    chk("t4_word",    rxw(0), 32'h1234);
    pulse_clr();
    chk("t4_frm_clr", {31'h0, frm_err}, 32'h0);
    chk("t4_cnt_clr", {24'h0, err_cnt}, 32'h0);

    // Flush with queued words and a partial word in the deserializer
    st_rdy = 1'b0;
    rx_q.delete();
    for (int k = 0; k < 5; k++) send_word(16'h0200 + 16'(k));
    for (int i = 0; i < 5; i++) send_bit(i == 0, 1'b0);
    link_idle();
    wait_cyc(4);
    chk("t5_level_pre", {28'h0, level}, 32'h5);
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    chk("t5_vld",   {31'h0, st_vld}, 32'h0);
    chk("t5_level", {28'h0, level},  32'h0);
    st_rdy = 1'b1;
    send_word(16'hBEEF);
    link_idle();
    wait_cyc(6);
    chk("t5_count",   rx_q.size(), 1);
    chk("t5_word",    rxw(0), 32'hBEEF);
    chk("t5_frm_err", {31'h0, frm_err}, 32'h0);

`ifdef RCVR_TIMEOUT_EN
    // Link stalls after 9 bits; the timeout discards the partial word
    rx_q.delete();
    for (int i = 0; i < 9; i++) send_bit(i == 0, 1'b1);
    link_idle();
    wait_cyc(300);
    chk("to_frm_err", {31'h0, frm_err}, 32'h1);
    chk("to_err_cnt", {24'h0, err_cnt}, 32'h1);
    send_word(16'h00FF);
    link_idle();
    wait_cyc(6);
    chk("to_count", rx_q.size(), 1);
    chk("to_word",  rxw(0), 32'h00FF);
    pulse_clr();
`endif

    // Error counter saturation: 258 fs bits give 257 framing errors
    for (int i = 0; i < 258; i++) send_bit(1'b1, 1'b0);
    link_idle();
    wait_cyc(4);
    chk("sat_err_cnt", {24'h0, err_cnt}, 32'hFF);
    chk("sat_frm_err", {31'h0, frm_err}, 32'h1);
    pulse_clr();
    chk("sat_cnt_clr", {24'h0, err_cnt}, 32'h0);

    // Clear coinciding with a framing error: the error wins, count restarts at 1
    rcv_fs = 1'b1;
    @(negedge sys_clk);
    rcv_clk = 1'b1;
    @(negedge sys_clk);
    rcv_clk = 1'b0;
    @(negedge sys_clk);
    clr_err = 1'b1;
    @(negedge sys_clk);
    clr_err = 1'b0;
    rcv_fs  = 1'b0;
    wait_cyc(2);
    chk("clr_race_cnt", {24'h0, err_cnt}, 32'h1);
    chk("clr_race_frm", {31'h0, frm_err}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
